// File: rtl/macpu_bus_pkg.sv
// Shared MACPU system-bus definitions: address map, FSM states, decode classes.
package macpu_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] ROM_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] ROM_LAST = 16'h00FF;
  localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0800;
  localparam logic [ADDR_W-1:0] RAM_LAST = 16'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } bus_state_t;

  typedef enum logic [1:0] {
    DEC_ROM = 2'd0,
    DEC_RAM = 2'd1,
    DEC_ERR = 2'd2
  } bus_dec_t;

  // Request payload as presented by one master.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Classify a byte address into the ROM window, the RAM window or unmapped.
  function automatic bus_dec_t decode_addr(input logic [ADDR_W-1:0] a);
    bus_dec_t d;
    if ((a >= ROM_BASE) && (a <= ROM_LAST))      d = DEC_ROM;
    else if ((a >= RAM_BASE) && (a <= RAM_LAST)) d = DEC_RAM;
    else                                         d = DEC_ERR;
    return d;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One master's request/response port on the MACPU system bus.
interface mem_bus_arbiter_if;
  import macpu_bus_pkg::*;

  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, rw, addr, wdata, lock, input gnt, ack, err, rdata);
  modport slave  (input req, rw, addr, wdata, lock, output gnt, ack, err, rdata);
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address decoder, shared with the CPU fetch unit.
module bus_addr_decode
  import macpu_bus_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic              rom_cs_o,
  output logic              ram_cs_o,
  output logic              err_o
);

  bus_dec_t dec;

  // Map the decode class onto one-hot select/error lines.
  always_comb begin
    dec      = decode_addr(addr_i);
    rom_cs_o = (dec == DEC_ROM);
    ram_cs_o = (dec == DEC_RAM);
    err_o    = (dec == DEC_ERR);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin bus arbiter and ROM/RAM controller with wait states and bus lock.
module mem_bus_arbiter
  import macpu_bus_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rw,
  output logic              o_rom_cs,
  output logic              o_ram_cs,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned CNT_W  = $clog2(LOCK_MAX + 1);

  bus_state_t              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rom_cs_q, rom_cs_d;
  logic                    ram_cs_q, ram_cs_d;
  logic                    o_rw_q, o_rw_d;
  logic                    terr_q, terr_d;

  logic [1:0] req_c, lock_c;
  bus_req_t   m0_req_c, m1_req_c, sel_req_c;
  logic       win_c, sel_c, latch_c, chain_c;
  logic       dec_rom_c, dec_ram_c, dec_err_c;

  assign req_c    = {m1.req, m0.req};
  assign lock_c   = {m1.lock, m0.lock};
  assign m0_req_c = '{rw: m0.rw, addr: m0.addr, wdata: m0.wdata};
  assign m1_req_c = '{rw: m1.rw, addr: m1.addr, wdata: m1.wdata};

  // Winner: a lone requester, otherwise the master not served last.
  assign win_c     = (req_c == 2'b11) ? ~last_q : req_c[1];
  assign sel_c     = (state_q == ST_IDLE) ? win_c : owner_q;
  assign sel_req_c = sel_c ? m1_req_c : m0_req_c;
  assign chain_c   = req_c[owner_q] & lock_c[owner_q] & (lock_cnt_q < CNT_W'(LOCK_MAX));

  bus_addr_decode u_decode (
    .addr_i   (sel_req_c.addr),
    .rom_cs_o (dec_rom_c),
    .ram_cs_o (dec_ram_c),
    .err_o    (dec_err_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    wait_d     = wait_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = '0;
    rdata_d    = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rom_cs_d   = rom_cs_q;
    ram_cs_d   = ram_cs_q;
    o_rw_d     = o_rw_q;
    terr_d     = terr_q;
    latch_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          latch_c    = 1'b1;
          owner_d    = win_c;
          gnt_d      = win_c ? 2'b10 : 2'b01;
          lock_cnt_d = '0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          state_d          = ST_ACK;
          ack_d[owner_q]   = 1'b1;
          err_d[owner_q]   = terr_q;
          rdata_d[owner_q] = terr_q ? '0 : i_rdata;
          rom_cs_d         = 1'b0;
          ram_cs_d         = 1'b0;
          o_rw_d           = 1'b0;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_ACK: begin
        if (chain_c) begin
          latch_c    = 1'b1;
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
          state_d    = ST_ACCESS;
        end else begin
          gnt_d      = '0;
          lock_cnt_d = '0;
          last_d     = owner_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture the selected request and its decode for the coming ACCESS phase.
    if (latch_c) begin
      addr_d   = sel_req_c.addr;
      wdata_d  = sel_req_c.wdata;
      rom_cs_d = dec_rom_c & ~sel_req_c.rw;
      ram_cs_d = dec_ram_c;
      o_rw_d   = dec_ram_c & sel_req_c.rw;
      terr_d   = dec_err_c | (dec_rom_c & sel_req_c.rw);
      wait_d   = dec_ram_c ? WAIT_W'(RAM_WAIT) : '0;
    end
  end

  // State and output registers; reset clears everything and aborts any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      wait_q     <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rom_cs_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      o_rw_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      wait_q     <= wait_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rom_cs_q   <= rom_cs_d;
      ram_cs_q   <= ram_cs_d;
      o_rw_q     <= o_rw_d;
      terr_q     <= terr_d;
    end
  end

  assign m0.gnt   = gnt_q[0];
  assign m0.ack   = ack_q[0];
  assign m0.err   = err_q[0];
  assign m0.rdata = rdata_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m1.ack   = ack_q[1];
  assign m1.err   = err_q[1];
  assign m1.rdata = rdata_q[1];

  assign o_addr   = addr_q;
  assign o_wdata  = wdata_q;
  assign o_rw     = o_rw_q;
  assign o_rom_cs = rom_cs_q;
  assign o_ram_cs = ram_cs_q;

endmodule
